// File: rtl/seg_map_ems.sv
// rtl/seg_map_ems.sv - segment and EMS page mapper with registered translation and context save/restore
module seg_map_ems #(
    parameter int SEG_BITS                  = 4,
    parameter int PAGE_BITS                 = 5,
    parameter int NWIN                      = 4,
    parameter logic [SEG_BITS-1:0] EMS_SEG  = 4'hA,
    parameter int EMS_PAGE_BITS             = 6,
    parameter logic [PAGE_BITS+1:0] EMS_BASE = 7'h40
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [SEG_BITS-1:0]   cpuaddr,
    input  logic [7:0]            cpuwdata,
    output logic [7:0]            cpurdata,
    input  logic                  WE,
    input  logic                  WE_EMS,
    input  logic                  EMS_OE,
    input  logic                  CTX_SAVE,
    input  logic                  CTX_RESTORE,
    output logic                  BUSY,
    input  logic [SEG_BITS+1:0]   memaddr,
    input  logic                  memreq,
    output logic [PAGE_BITS+1:0]  memdata,
    output logic                  memvalid,
    output logic                  f_map_to_f,
    output logic                  ems_active
);

    localparam int WIN_BITS = $clog2(NWIN);
    localparam int NSEG     = 2 ** SEG_BITS;
    localparam int XW       = PAGE_BITS + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE} state_t;

    state_t                     state_q, state_d;
    logic [WIN_BITS-1:0]        cnt_q;
    logic                       cnt_last;

    logic [PAGE_BITS-1:0]       map_q     [NSEG];
    logic [NWIN-1:0]            live_en;
    logic [EMS_PAGE_BITS-1:0]   live_pg   [NWIN];
    logic [NWIN-1:0]            shad_en;
    logic [EMS_PAGE_BITS-1:0]   shad_pg   [NWIN];

    logic [WIN_BITS-1:0]        ci;
    logic [7:0]                 rd_next;
    logic [SEG_BITS-1:0]        s, sdiff;
    logic [1:0]                 w;
    logic [WIN_BITS-1:0]        k;
    logic                       in_ems;
    logic [XW-1:0]              xlat;

    assign BUSY       = (state_q != ST_IDLE);
    assign cnt_last   = (cnt_q == WIN_BITS'(NWIN - 1));
    assign ems_active = |live_en;
    assign f_map_to_f = (map_q[NSEG-1] == PAGE_BITS'(NSEG - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (CTX_SAVE)
                    state_d = ST_SAVE;
                else if (CTX_RESTORE)
                    state_d = ST_RESTORE;
            end
            ST_SAVE, ST_RESTORE: begin
                if (cnt_last)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_IDLE || cnt_last) ? '0 : cnt_q + 1'b1;
        end
    end

    // Window index k concatenates the segment offset within the EMS area with the 16 KB window.
    assign s      = memaddr[SEG_BITS+1:2];
    assign w      = memaddr[1:0];
    assign sdiff  = s - EMS_SEG;
    assign in_ems = (s >= EMS_SEG) && (sdiff < SEG_BITS'(NWIN / 4));

    generate
        if (WIN_BITS == 2) begin : g_k4
            assign k = w;
        end else begin : g_k8
            assign k = {sdiff[WIN_BITS-3:0], w};
        end
    endgenerate

    always_comb begin
        xlat = {map_q[s], w};
        if (in_ems && live_en[k])
            xlat = EMS_BASE + XW'(live_pg[k]);
    end

    assign ci = cpuaddr[WIN_BITS-1:0];

    always_comb begin
        rd_next = 8'(map_q[cpuaddr]);
        if (EMS_OE)
            rd_next = live_en[ci] ? 8'(live_pg[ci]) : 8'hFF;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int j = 0; j < NSEG; j++)
                map_q[j] <= PAGE_BITS'(j);
            for (int j = 0; j < NWIN; j++) begin
                live_pg[j] <= '0;
                shad_pg[j] <= '0;
            end
            live_en  <= '0;
            shad_en  <= '0;
            cpurdata <= '0;
            memdata  <= '0;
            memvalid <= 1'b0;
        end else begin
            cpurdata <= rd_next;
            memvalid <= memreq;
            if (memreq)
                memdata <= xlat;

            if (WE_EMS) begin
                if (!BUSY) begin
                    if (cpuwdata == 8'hFF) begin
                        live_en[ci] <= 1'b0;
                        live_pg[ci] <= '1;
                    end else if ((cpuwdata >> EMS_PAGE_BITS) == 8'd0) begin
                        live_en[ci] <= 1'b1;
                        live_pg[ci] <= cpuwdata[EMS_PAGE_BITS-1:0];
                    end
                end
            end else if (WE) begin
                map_q[cpuaddr] <= cpuwdata[PAGE_BITS-1:0];
            end

            if (state_q == ST_SAVE) begin
                shad_en[cnt_q] <= live_en[cnt_q];
                shad_pg[cnt_q] <= live_pg[cnt_q];
            end
            if (state_q == ST_RESTORE) begin
                live_en[cnt_q] <= shad_en[cnt_q];
                live_pg[cnt_q] <= shad_pg[cnt_q];
            end
        end
    end

endmodule

// File: tb/tb_seg_map_ems.sv
// tb/tb_seg_map_ems.sv - directed self-checking bench for seg_map_ems
module tb_seg_map_ems;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] cpuaddr;
    logic [7:0] cpuwdata;
    logic [7:0] cpurdata;
    logic       WE, WE_EMS, EMS_OE, CTX_SAVE, CTX_RESTORE, BUSY;
    logic [5:0] memaddr;
    logic       memreq;
    logic [6:0] memdata;
    logic       memvalid, f_map_to_f, ems_active;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;

    seg_map_ems dut (
        .CLK(CLK), .RST_N(RST_N), .cpuaddr(cpuaddr), .cpuwdata(cpuwdata),
        .cpurdata(cpurdata), .WE(WE), .WE_EMS(WE_EMS), .EMS_OE(EMS_OE),
        .CTX_SAVE(CTX_SAVE), .CTX_RESTORE(CTX_RESTORE), .BUSY(BUSY),
        .memaddr(memaddr), .memreq(memreq), .memdata(memdata),
        .memvalid(memvalid), .f_map_to_f(f_map_to_f), .ems_active(ems_active)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ems_wr(input logic [3:0] idx, input logic [7:0] val);
        cpuaddr = idx; cpuwdata = val; WE_EMS = 1'b1;
        tick();
        WE_EMS = 1'b0;
    endtask

    task automatic ems_rd(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        cpuaddr = idx; EMS_OE = 1'b1;
        tick();
        check(tag, cpurdata, exp);
        EMS_OE = 1'b0;
    endtask

    task automatic xlat(input string tag, input logic [5:0] a, input logic [6:0] exp);
        memaddr = a; memreq = 1'b1;
        tick();
        memreq = 1'b0;
        check({tag, "_valid"}, memvalid, 1);
        check(tag, memdata, exp);
    endtask

    // Counts cycles with BUSY high, starting right after the pulse edge.
    task automatic count_busy(input bit poke_we_ems, input bit poke_restore);
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (!BUSY) break;
            busy_cnt++;
            if (c == 0 && poke_we_ems) begin
                cpuaddr = 4'd0; cpuwdata = 8'h3F; WE_EMS = 1'b1;
            end
            if (c == 1 && poke_restore) CTX_RESTORE = 1'b1;
            tick();
            WE_EMS = 1'b0; CTX_RESTORE = 1'b0;
        end
    endtask

    initial begin
        RST_N = 1'b0; cpuaddr = '0; cpuwdata = '0; WE = 0; WE_EMS = 0; EMS_OE = 0;
        CTX_SAVE = 0; CTX_RESTORE = 0; memaddr = '0; memreq = 0;
        tick(); tick();
        check("rst_cpurdata", cpurdata, 0);
        check("rst_memdata", memdata, 0);
        check("rst_memvalid", memvalid, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ems_active", ems_active, 0);
        check("rst_f_map_to_f", f_map_to_f, 1);
        RST_N = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cpuaddr = 4'(i);
            tick();
            check($sformatf("seg_rd%0d", i), cpurdata, i);
        end
        check("idle_memvalid", memvalid, 0);

        ems_wr(4'd2, 8'h15);
        ems_rd("ems_rd_15", 4'd2, 8'h15);
        check("ems_active_on", ems_active, 1);
        xlat("xlat_ems", 6'h2A, 7'h55);
        tick();
        check("memvalid_drop", memvalid, 0);

        ems_wr(4'd2, 8'h50);
        ems_rd("ems_rd_ign50", 4'd2, 8'h15);
        ems_wr(4'd2, 8'hFF);
        ems_rd("ems_rd_ff", 4'd2, 8'hFF);
        check("ems_active_off", ems_active, 0);
        xlat("xlat_ems_off", 6'h2A, 7'h2A);

        cpuaddr = 4'd15; cpuwdata = 8'h03; WE = 1'b1;
        tick();
        WE = 1'b0;
        check("f_map_to_f_clr", f_map_to_f, 0);
        xlat("xlat_seg15", 6'h3D, 7'h0D);

        for (int i = 0; i < 4; i++) ems_wr(4'(i), 8'(i + 1));
        CTX_SAVE = 1'b1;
        tick();
        CTX_SAVE = 1'b0;
        count_busy(1'b1, 1'b0);
        check("save_busy_len", busy_cnt, 4);
        ems_rd("we_ems_busy_drop", 4'd0, 8'h01);

        for (int i = 0; i < 4; i++) ems_wr(4'(i), 8'h09);
        ems_rd("live_9", 4'd3, 8'h09);
        CTX_RESTORE = 1'b1;
        tick();
        CTX_RESTORE = 1'b0;
        count_busy(1'b0, 1'b0);
        check("restore_busy_len", busy_cnt, 4);
        for (int i = 0; i < 4; i++)
            ems_rd($sformatf("restored%0d", i), 4'(i), 8'(i + 1));

        for (int i = 0; i < 4; i++) ems_wr(4'(i), 8'h07);
        CTX_SAVE = 1'b1; CTX_RESTORE = 1'b1;
        tick();
        CTX_SAVE = 1'b0; CTX_RESTORE = 1'b0;
        count_busy(1'b0, 1'b1);
        check("both_busy_len", busy_cnt, 4);
        tick();
        check("no_retrigger", BUSY, 0);
        ems_rd("save_won", 4'd0, 8'h07);
        for (int i = 0; i < 4; i++) ems_wr(4'(i), 8'h05);
        CTX_RESTORE = 1'b1;
        tick();
        CTX_RESTORE = 1'b0;
        count_busy(1'b0, 1'b0);
        ems_rd("shadow_saved7", 4'd1, 8'h07);

        for (int i = 0; i < 4; i++) ems_wr(4'(i), 8'h09);
        memaddr = 6'h2A; memreq = 1'b1; EMS_OE = 1'b1; cpuaddr = 4'd0;
        CTX_RESTORE = 1'b1;
        tick();
        CTX_RESTORE = 1'b0;
        tick();
        RST_N = 1'b0;
        tick();
        memreq = 1'b0; EMS_OE = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_cpurdata", cpurdata, 0);
        check("abort_memdata", memdata, 0);
        check("abort_memvalid", memvalid, 0);
        check("abort_ems_active", ems_active, 0);
        check("abort_f_map_to_f", f_map_to_f, 1);
        RST_N = 1'b1;
        ems_rd("abort_live0", 4'd0, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
